// File: rtl/sounder_pkg.sv
// Shared channel-sounder definitions: FSM encoding, degree limits,
// LFSR seed and the Galois step used by both TX and RX code generators.
package sounder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0]  DEG_MIN   = 5'd2;
    localparam logic [4:0]  DEG_MAX   = 5'd16;
    localparam logic [15:0] LFSR_SEED = 16'h0001;

    // Right-shifting Galois step: the bit shifted out is the chip and,
    // when set, folds the feedback mask back into the register.
    function automatic logic [15:0] lfsr_next(
        input logic [15:0] s,
        input logic [15:0] mask
    );
        return (s >> 1) ^ (s[0] ? mask : 16'h0000);
    endfunction

endpackage

// File: rtl/sounder_pn_gen.sv
// M-sequence generator: LFSR with seed, single step and step+slip.
// Ports: clk/rst_n, seed, step, slip (extra step with step), mask, chip.
module sounder_pn_gen
    import sounder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed,
    input  logic        step,
    input  logic        slip,
    input  logic [15:0] mask,
    output logic        chip
);

    logic [15:0] state;

    assign chip = state[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (seed) begin
            state <= LFSR_SEED;
        end else if (step && slip) begin
            state <= lfsr_next(lfsr_next(state, mask), mask);
        end else if (step) begin
            state <= lfsr_next(state, mask);
        end
    end

endmodule

// File: rtl/sounder_rx_correlator.sv
// Sliding correlator: despreads I/Q against a local m-sequence, dumps one
// complex result per code period and slips the code one chip per period.
// Ports: clk_i/rst_ni, ena_i, degree_i/mask_i config, strobe_i/real_i/imag_i
// samples in; strobe_o/real_o/imag_o/lag_o results, busy_o, cfg_err_o.
module sounder_rx_correlator
    import sounder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        ena_i,
    input  logic [4:0]                  degree_i,
    input  logic [15:0]                 mask_i,
    input  logic                        strobe_i,
    input  logic signed [WIDTH-1:0]     real_i,
    input  logic signed [WIDTH-1:0]     imag_i,
    output logic                        strobe_o,
    output logic signed [ACC_WIDTH-1:0] real_o,
    output logic signed [ACC_WIDTH-1:0] imag_o,
    output logic [15:0]                 lag_o,
    output logic                        busy_o,
    output logic                        cfg_err_o
);

    state_t                      state;
    logic [15:0]                 mask_q;
    logic [15:0]                 last_q;
    logic [15:0]                 count;
    logic [15:0]                 lag;
    logic signed [ACC_WIDTH-1:0] acc_re;
    logic signed [ACC_WIDTH-1:0] acc_im;

    logic                        chip;
    logic                        deg_ok;
    logic                        run_strobe;
    logic                        dump;
    logic                        seed;
    logic signed [ACC_WIDTH-1:0] re_x;
    logic signed [ACC_WIDTH-1:0] im_x;
    logic signed [ACC_WIDTH-1:0] re_c;
    logic signed [ACC_WIDTH-1:0] im_c;

    assign deg_ok     = (degree_i >= DEG_MIN) && (degree_i <= DEG_MAX);
    assign run_strobe = (state == RUN) && ena_i && strobe_i;
    assign dump       = run_strobe && (count == last_q);
    assign seed       = (state == IDLE) && ena_i && deg_ok;
    assign busy_o     = (state == RUN);

    assign re_x = {{(ACC_WIDTH-WIDTH){real_i[WIDTH-1]}}, real_i};
    assign im_x = {{(ACC_WIDTH-WIDTH){imag_i[WIDTH-1]}}, imag_i};
    assign re_c = chip ? re_x : -re_x;
    assign im_c = chip ? im_x : -im_x;

    // Dump cycle steps the code twice, rotating the phase by one chip
    sounder_pn_gen u_pn (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .seed  (seed),
        .step  (run_strobe),
        .slip  (dump),
        .mask  (mask_q),
        .chip  (chip)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            mask_q    <= '0;
            last_q    <= '0;
            count     <= '0;
            lag       <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            strobe_o  <= 1'b0;
            real_o    <= '0;
            imag_o    <= '0;
            lag_o     <= '0;
            cfg_err_o <= 1'b0;
        end else begin
            strobe_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ena_i && deg_ok) begin
                        state  <= RUN;
                        mask_q <= mask_i;
                        // N-1 = 2^degree - 2, the index of the last chip
                        last_q <= 16'((17'd1 << degree_i) - 17'd2);
                        count  <= '0;
                        lag    <= '0;
                        acc_re <= '0;
                        acc_im <= '0;
                    end else if (ena_i) begin
                        cfg_err_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (!ena_i) begin
                        state <= IDLE;
                    end else if (dump) begin
                        real_o   <= acc_re + re_c;
                        imag_o   <= acc_im + im_c;
                        lag_o    <= lag;
                        strobe_o <= 1'b1;
                        acc_re   <= '0;
                        acc_im   <= '0;
                        count    <= '0;
                        lag      <= (lag == last_q) ? 16'd0 : lag + 16'd1;
                    end else if (run_strobe) begin
                        acc_re <= acc_re + re_c;
                        acc_im <= acc_im + im_c;
                        count  <= count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sounder_rx_correlator.sv
// Directed bench for sounder_rx_correlator.
// Checks period dumps, lag sweep, enable drop, config error and async reset.
module tb_sounder_rx_correlator;

    logic               clk;
    logic               rst_n;
    logic               ena;
    logic [4:0]         degree;
    logic [15:0]        mask;
    logic               strobe_in;
    logic signed [15:0] re_in;
    logic signed [15:0] im_in;
    logic               strobe_out;
    logic signed [31:0] re_out;
    logic signed [31:0] im_out;
    logic [15:0]        lag_out;
    logic               busy;
    logic               cfg_err;

    int total = 0;
    int bad   = 0;

    sounder_rx_correlator #(.WIDTH(16), .ACC_WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ena_i     (ena),
        .degree_i  (degree),
        .mask_i    (mask),
        .strobe_i  (strobe_in),
        .real_i    (re_in),
        .imag_i    (im_in),
        .strobe_o  (strobe_out),
        .real_o    (re_out),
        .imag_o    (im_out),
        .lag_o     (lag_out),
        .busy_o    (busy),
        .cfg_err_o (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic [4:0] d, input logic [15:0] m);
        ena       = 1'b1;
        degree    = d;
        mask      = m;
        strobe_in = 1'b0;
        tick();
        chk("busy_on", busy, 1);
    endtask

    task automatic stop();
        ena       = 1'b0;
        strobe_in = 1'b0;
        tick();
        chk("busy_off", busy, 0);
        chk("no_strobe_stop", strobe_out, 0);
    endtask

    // n: period, np: periods, gap: clocks per strobe,
    // mode 0: constant er/ei input; mode 1: TX-code-modulated I (deg 3)
    task automatic run(input int n, input int np, input int gap,
                       input int mode, input int er, input int ei);
        int sc = 0;
        int c = 0;
        int lg = 0;
        logic [15:0] tx = 16'h0001;
        logic drv;
        logic exp_s;
        int want_r;
        while (sc < n * np) begin
            drv = ((c % gap) == 0);
            strobe_in = drv;
            if (mode == 1) begin
                re_in = tx[0] ? 16'sd1000 : -16'sd1000;
                im_in = 16'sd0;
            end else begin
                re_in = 16'(er);
                im_in = 16'(ei);
            end
            tick();
            if (drv) begin
                sc++;
                if (mode == 1)
                    tx = (tx >> 1) ^ (tx[0] ? 16'h0005 : 16'h0000);
            end
            exp_s = drv && ((sc % n) == 0);
            chk("strobe", strobe_out, exp_s);
            if (exp_s) begin
                want_r = (mode == 1) ? ((lg == 0) ? 7000 : -1000) : er;
                chk("real", re_out, want_r);
                chk("imag", im_out, (mode == 1) ? 0 : ei);
                chk("lag", lag_out, lg);
                lg = (lg + 1) % n;
            end
            c++;
        end
        strobe_in = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b0;
        degree    = 5'd3;
        mask      = 16'h0005;
        strobe_in = 1'b0;
        re_in     = '0;
        im_in     = '0;
        #12;
        chk("rst_strobe", strobe_out, 0);
        chk("rst_real", re_out, 0);
        chk("rst_imag", im_out, 0);
        chk("rst_lag", lag_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // constant input, lags 0..6 then wrap to 0
        start(5'd3, 16'h0005);
        run(7, 8, 1, 0, 100, -50);
        stop();

        // TX-modulated input: peak at lag 0 only
        start(5'd3, 16'h0005);
        run(7, 8, 1, 1, 0, 0);
        stop();

        // degree 4, strobe every 3rd clock
        start(5'd4, 16'h0009);
        run(15, 2, 3, 0, 7, -3);
        stop();

        // drop enable mid-period; outputs hold, no strobe
        start(5'd3, 16'h0005);
        for (int i = 0; i < 4; i++) begin
            strobe_in = 1'b1;
            re_in     = 16'sd100;
            im_in     = -16'sd50;
            tick();
            chk("partial_no_strobe", strobe_out, 0);
        end
        stop();
        tick();
        chk("hold_real", re_out, 7);
        chk("hold_imag", im_out, -3);
        chk("hold_lag", lag_out, 1);
        start(5'd3, 16'h0005);
        run(7, 1, 1, 0, 100, -50);
        stop();

        // out-of-range degree
        ena    = 1'b1;
        degree = 5'd17;
        tick();
        chk("deg17_busy", busy, 0);
        chk("deg17_err", cfg_err, 1);
        ena = 1'b0;
        tick();
        chk("err_sticky", cfg_err, 1);
        ena    = 1'b1;
        degree = 5'd1;
        tick();
        chk("deg1_busy", busy, 0);
        chk("deg1_err", cfg_err, 1);
        ena = 1'b0;
        tick();
        chk("err_sticky2", cfg_err, 1);

        // async reset mid-run
        start(5'd3, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            strobe_in = 1'b1;
            re_in     = 16'sd100;
            im_in     = -16'sd50;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_strobe", strobe_out, 0);
        chk("arst_real", re_out, 0);
        chk("arst_imag", im_out, 0);
        chk("arst_lag", lag_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cfg_err", cfg_err, 0);
        strobe_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rerun_busy", busy, 1);
        run(7, 2, 1, 0, 100, -50);
        stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
